mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 8 +
 rtl/mem_port_arbiter_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter FSM encoding and default memory-port parameters.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    localparam int ARB_ADDR_W       = 32;
    localparam int ARB_DATA_W       = 32;
    localparam int ARB_MAX_D_STREAK = 4;
    localparam int ARB_TIMEOUT      = 255;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: counts BUSY cycles without mem_ready and raises a sticky error on expiry.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_busy,
    input  logic i_ready,
    output logic o_timeout,
    output logic o_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_err;
    assign o_timeout = i_busy & ~i_ready & (r_cnt == CW'(TIMEOUT - 1));
    assign o_err     = r_err;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (i_busy & ~i_ready & ~o_timeout) ? r_cnt + 1'b1 : '0;
            r_err <= r_err | o_timeout;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters,
// data-first with a streak limit so a waiting fetch cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int MAX_D_STREAK = ARB_MAX_D_STREAK,
    parameter int TIMEOUT      = ARB_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    arb_state_t        r_state, w_next;
    logic              r_gnt_d, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata, w_rdata;
    logic [SW-1:0]     r_streak;
    logic              w_any, w_pick_d, w_grant, w_done, w_timeout;

    // Data wins unless it has already taken MAX_D_STREAK grants past a waiting fetch
    assign w_any    = if_req | d_req;
    assign w_pick_d = d_req & ~(if_req & (r_streak == SW'(MAX_D_STREAK)));
    assign w_grant  = (r_state == IDLE) & w_any;
    assign w_done   = (r_state == BUSY) & (mem_ready | w_timeout);
    assign w_rdata  = w_timeout ? '0 : mem_rdata;

    assign mem_req   = (r_state == BUSY);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == DONE) & ~r_gnt_d;
    assign d_ack     = (r_state == DONE) & r_gnt_d;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .i_busy    (mem_req),
        .i_ready   (mem_ready),
        .o_timeout (w_timeout),
        .o_err     (err)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? BUSY : IDLE;
            BUSY:    w_next = (mem_ready | w_timeout) ? DONE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_gnt_d    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt_d  <= w_pick_d;
                r_we     <= w_pick_d & d_we;
                r_addr   <= w_pick_d ? d_addr : if_addr;
                r_wdata  <= w_pick_d ? d_wdata : '0;
                r_streak <= (w_pick_d & if_req) ? r_streak + 1'b1 : '0;
            end
            if (w_done & r_gnt_d) r_d_rdata <= w_rdata;
            if (w_done & ~r_gnt_d) r_if_rdata <= w_rdata;
        end
    end
endmodule
